// File: rtl/load_store_pkg.sv
// rtl/load_store_pkg.sv - Order encodings and FSM state type for the load/store pipe.
package load_store_pkg;

  localparam logic [1:0] ORDER_BYTE = 2'b00;
  localparam logic [1:0] ORDER_HALF = 2'b01;
  localparam logic [1:0] ORDER_WORD = 2'b10;
  localparam logic [1:0] ORDER_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } ldst_state_t;

endpackage

// File: rtl/load_store_read_align.sv
// rtl/load_store_read_align.sv - Big-endian lane select and zero-extension of a read word.
module load_store_read_align
  import load_store_pkg::*;
(
  input  logic [1:0]  order,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] result
);

  // Byte offset 0 lives in bits 31:24; addr_lo[0] is a don't-care for halves.
  always_comb begin
    result = '0;
    case (order)
      ORDER_BYTE: begin
        case (addr_lo)
          2'd0:    result = {24'd0, word[31:24]};
          2'd1:    result = {24'd0, word[23:16]};
          2'd2:    result = {24'd0, word[15:8]};
          default: result = {24'd0, word[7:0]};
        endcase
      end
      ORDER_HALF: result = addr_lo[1] ? {16'd0, word[15:0]} : {16'd0, word[31:16]};
      ORDER_WORD: result = word;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_pipe.sv
// rtl/load_store_pipe.sv - Single-outstanding load/store engine between the arbiter and data memory.
module load_store_pipe
  import load_store_pkg::*;
(
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iLDST_REQ,
  output logic        oLDST_BUSY,
  input  logic [1:0]  iLDST_ORDER,
  input  logic [3:0]  iLDST_MASK,
  input  logic        iLDST_RW,
  input  logic [31:0] iLDST_ADDR,
  input  logic [31:0] iLDST_DATA,
  output logic        oLDST_VALID,
  output logic [31:0] oLDST_DATA,
  output logic        oDATA_REQ,
  input  logic        iDATA_BUSY,
  output logic [1:0]  oDATA_ORDER,
  output logic [3:0]  oDATA_MASK,
  output logic        oDATA_RW,
  output logic [31:0] oDATA_ADDR,
  output logic [31:0] oDATA_DATA,
  input  logic        iDATA_VALID,
  input  logic [31:0] iDATA_DATA
);

  ldst_state_t state;
  ldst_state_t state_next;

  logic [1:0]  order_q;
  logic [3:0]  mask_q;
  logic        rw_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] result_q;
  logic [31:0] aligned;

  logic accept;
  logic mem_taken;
  logic rdata_take;

  assign accept     = (state == IDLE) && iLDST_REQ;
  assign mem_taken  = (state == REQ) && !iDATA_BUSY;
  assign rdata_take = (state == WAIT) && iDATA_VALID;

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (iLDST_REQ) begin
          state_next = (iLDST_ORDER == ORDER_NONE) ? DONE : REQ;
        end
      end
      REQ: begin
        if (!iDATA_BUSY) begin
          state_next = rw_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (iDATA_VALID) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    oLDST_BUSY  = (state != IDLE);
    oDATA_REQ   = (state == REQ);
    oLDST_VALID = (state == DONE);
  end

  // Holding registers only load in IDLE, so a request held high while busy is ignored.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      order_q <= '0;
      mask_q  <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (accept) begin
      order_q <= iLDST_ORDER;
      mask_q  <= iLDST_MASK;
      rw_q    <= iLDST_RW;
      addr_q  <= iLDST_ADDR;
      data_q  <= iLDST_DATA;
    end
  end

  load_store_read_align u_read_align (
    .order   (order_q),
    .addr_lo (addr_q[1:0]),
    .word    (iDATA_DATA),
    .result  (aligned)
  );

  // Result is registered so iDATA_* never reaches oLDST_DATA combinationally.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      result_q <= '0;
    end else if (accept && (iLDST_ORDER == ORDER_NONE)) begin
      result_q <= '0;
    end else if (mem_taken && rw_q) begin
      result_q <= '0;
    end else if (rdata_take) begin
      result_q <= aligned;
    end
  end

  assign oLDST_DATA  = result_q;
  assign oDATA_ORDER = order_q;
  assign oDATA_MASK  = mask_q;
  assign oDATA_RW    = rw_q;
  assign oDATA_ADDR  = {addr_q[31:2], 2'b00};
  assign oDATA_DATA  = data_q;

endmodule

// File: doc/load_store_pipe.md
# load_store_pipe

Single-outstanding load/store engine that sits directly downstream of the load/store pipe arbiter. It consumes the arbiter's muxed request (order, mask, read/write, address, data) and drives the core's data-memory port. It aligns and zero-extends read data by byte order. It then returns a one-cycle valid pulse with the result, which the arbiter routes back to the execution or exception unit.

## Interface
Parameters: none.

Clock and reset:
- iCLOCK  in  1  core clock; all state changes on the rising edge.
- iRESET_SYNC  in  1  synchronous, active-high reset.

Arbiter side (request):
- iLDST_REQ  in  1  request strobe; accepted when high and oLDST_BUSY low.
- oLDST_BUSY  out  1  high in every state except IDLE.
- iLDST_ORDER  in  2  access size: 00 byte, 01 2-byte, 10 word, 11 none.
- iLDST_MASK  in  4  byte-lane write mask; bit 3 = bits 31:24.
- iLDST_RW  in  1  0 read, 1 write.
- iLDST_ADDR  in  32  byte address.
- iLDST_DATA  in  32  write data, already lane-positioned.

Arbiter side (response):
- oLDST_VALID  out  1  one-cycle completion pulse.
- oLDST_DATA  out  32  read result, zero-extended; 0 for writes and for order 11.

Memory side:
- oDATA_REQ  out  1  memory request, held until accepted.
- iDATA_BUSY  in  1  memory cannot accept this cycle.
- oDATA_ORDER  out  2  latched order.
- oDATA_MASK  out  4  latched mask.
- oDATA_RW  out  1  latched read/write.
- oDATA_ADDR  out  32  word address {addr[31:2], 2'b00}.
- oDATA_DATA  out  32  latched write data.
- iDATA_VALID  in  1  read data strobe.
- iDATA_DATA  in  32  read word.

## Operation
- **Byte order.** Big-endian: byte offset 0 is bits 31:24.
- **States:**
  - IDLE.
  - REQ: memory request outstanding.
  - WAIT: read data pending.
  - DONE: result presented.
- **IDLE.**
  - iLDST_REQ=1 captures order, mask, rw, addr and data into holding registers.
  - Order 11 goes to DONE with result 0 and makes no memory access.
  - Any other order goes to REQ.
- **REQ.**
  - oDATA_REQ=1 and the oDATA_* fields come from the holding registers, stable the whole time.
  - At an edge with iDATA_BUSY=0 the request is taken: a write goes to DONE, a read goes to WAIT.
  - While iDATA_BUSY=1 the block stays in REQ.
- **WAIT.**
  - On iDATA_VALID=1, the extracted read value is registered and the block goes to DONE.
  - Extraction uses the latched addr[1:0]:
    - Byte: lane addr[1:0], with offset 0 taking bits 31:24.
    - 2-byte: addr[1]=0 takes bits 31:16, addr[1]=1 takes bits 15:0; addr[0] is ignored.
    - Word: the full word.
  - All results are zero-extended.
- **DONE.** oLDST_VALID=1 and oLDST_DATA holds the result for this one cycle; next state is IDLE.
- **Idle data.** oLDST_DATA holds its last value when idle.
- **Stray response.** iDATA_VALID while in IDLE, REQ or DONE is ignored.
- **Early request.** iLDST_REQ while busy is not accepted; the arbiter keeps it asserted.

## Timing
- **Reset.** iRESET_SYNC=1 at an edge forces IDLE and clears all holding registers. After reset, oLDST_BUSY=0, oLDST_VALID=0, oLDST_DATA=0, oDATA_REQ=0, oDATA_ORDER=0, oDATA_MASK=0, oDATA_RW=0, oDATA_ADDR=0, oDATA_DATA=0.
- **Reset mid-operation.** The transaction is abandoned with no valid pulse, and a late iDATA_VALID is dropped.
- **Write latency.** Accept at edge N; oDATA_REQ from N+1; memory accepts at edge N+1 when not busy; oLDST_VALID during cycle N+2. Each busy cycle adds 1.
- **Read latency.** Accept at N; REQ in N+1; WAIT from N+2; iDATA_VALID sampled earliest at edge N+2 end; oLDST_VALID earliest in cycle N+3.
- **Order 11.** oLDST_VALID in cycle N+1.
- **Throughput.** Back-to-back: the next accept is at the edge ending DONE+IDLE, giving at most one transaction per 3 cycles for writes.
- **Output registering.** All outputs are registered or decoded directly from the state register, with no combinational path from iDATA_* to oLDST_*.

## Structure
- Package `load_store_pkg` holds:
  - the order encoding constants (ORDER_BYTE=2'b00, ORDER_HALF=2'b01, ORDER_WORD=2'b10, ORDER_NONE=2'b11);
  - the state enum (IDLE, REQ, WAIT, DONE) as typedef `ldst_state_t`.
- One combinational sub-module, `load_store_read_align`, maps (order, addr[1:0], word) to a zero-extended 32-bit result. It is reusable by the fetch path.

## Test plan
- **Byte read:** read order 00 at addr 0x1003, memory returns 0xAABBCCDD after 2 wait cycles -> oDATA_ADDR=0x1000, oLDST_DATA=0x000000DD, one valid pulse.
- **Half read:** read order 01 at addr 0x2002, data 0x11223344 -> oLDST_DATA=0x00003344. Same at addr 0x2000 -> 0x00001122.
- **Write with busy:** write order 10 at addr 0x3000, data 0xCAFEBABE, mask 0xF, iDATA_BUSY high 3 cycles -> oDATA_REQ held 4 cycles with stable fields, oLDST_VALID exactly once, oLDST_DATA=0.
- **Order 11:** request with order 11 -> no oDATA_REQ, valid in the next cycle with data 0.
- **Reset in WAIT:** assert iRESET_SYNC while in WAIT, then iDATA_VALID arrives -> no oLDST_VALID, all outputs 0, a new request is accepted normally.
- **Early requests:** hold iLDST_REQ high through two consecutive reads -> exactly two memory requests and two valid pulses in order, and the second request is not captured while busy.
